panda_load_store_unit: RTL and testbench

//   Multi-cycle load/store unit between the core datapath and an external word-wide data memory.

---
 rtl/panda_load_store_unit_if.sv | 35 +++
 rtl/panda_load_store_unit.sv | 207 ++++++++++++++++++++
 tb/tb_panda_load_store_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_load_store_unit_if.sv
// Word-wide data memory bus with a req/gnt/rvalid handshake and one outstanding transaction.
interface panda_load_store_unit_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // The load/store unit issues requests.
    modport master (
        output req,
        output addr,
        output we,
        output be,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // The data memory answers them.
    modport slave (
        input  req,
        input  addr,
        input  we,
        input  be,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/panda_load_store_unit.sv
// Multi-cycle load/store unit: byte/half/word accesses to a word-wide data memory.
// Misaligned half/word accesses become two aligned word transactions. Otherwise they are
// flagged as errors, depending on MisalignedEn.
module panda_load_store_unit #(
    parameter bit MisalignedEn = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [1:0]                      width_i,
    input  logic                            unsigned_i,
    input  logic [31:0]                     addr_i,
    input  logic [31:0]                     wdata_i,
    output logic                            busy_o,
    output logic                            valid_o,
    output logic                            err_o,
    output logic [31:0]                     rdata_o,
    panda_load_store_unit_if.master         data_if
);

    typedef enum logic [2:0] {
        StIdle,
        StReq1,
        StWait1,
        StReq2,
        StWait2,
        StDone,
        StErr
    } state_e;

    state_e      state_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        data_req_q;
    logic [31:0] data_addr_q;
    logic        data_we_q;
    logic [3:0]  data_be_q;
    logic [31:0] data_wdata_q;

    // Latched request attributes needed after acceptance.
    logic [1:0]  off_q;
    logic [1:0]  width_q;
    logic        uns_q;
    logic        split_q;
    logic [31:0] wdata_q;
    logic [31:0] rd1_q;

    logic [2:0]  size_in;
    logic [3:0]  mask_in;
    logic        split_in;
    logic [3:0]  be1;
    logic [31:0] wdata1;
    logic [3:0]  mask_q;
    logic [2:0]  sh2;
    logic [3:0]  be2;
    logic [31:0] wdata2;
    logic [63:0] pair;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Size, lane mask and first-transaction lanes from the incoming request.
    always_comb begin
        size_in = 3'd4;
        mask_in = 4'b1111;
        unique case (width_i)
            2'b00: begin size_in = 3'd1; mask_in = 4'b0001; end
            2'b01: begin size_in = 3'd2; mask_in = 4'b0011; end
            default: begin size_in = 3'd4; mask_in = 4'b1111; end
        endcase
        split_in = (({1'b0, addr_i[1:0]} + size_in) > 3'd4);
        be1      = 4'(mask_in << addr_i[1:0]);
        wdata1   = wdata_i << {addr_i[1:0], 3'b000};
    end

    // Second-transaction lanes from the latched request: the bytes that spilled past the word.
    always_comb begin
        mask_q = 4'b1111;
        unique case (width_q)
            2'b00:   mask_q = 4'b0001;
            2'b01:   mask_q = 4'b0011;
            default: mask_q = 4'b1111;
        endcase
        sh2    = 3'd4 - {1'b0, off_q};
        be2    = mask_q >> sh2;
        wdata2 = wdata_q >> {sh2, 3'b000};
    end

    // Merge the returned word(s), align to bit 0 and extend to 32 bits.
    always_comb begin
        if (state_q == StWait2) begin
            pair = {data_if.rdata, rd1_q};
        end else begin
            pair = {32'h0, data_if.rdata};
        end
        shifted = 32'(pair >> {off_q, 3'b000});
        unique case (width_q)
            2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Access sequencer with registered bus and completion outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            data_req_q   <= 1'b0;
            data_addr_q  <= 32'h0;
            data_we_q    <= 1'b0;
            data_be_q    <= 4'h0;
            data_wdata_q <= 32'h0;
            off_q        <= 2'b00;
            width_q      <= 2'b00;
            uns_q        <= 1'b0;
            split_q      <= 1'b0;
            wdata_q      <= 32'h0;
            rd1_q        <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        off_q   <= addr_i[1:0];
                        width_q <= width_i;
                        uns_q   <= unsigned_i;
                        split_q <= split_in;
                        wdata_q <= wdata_i;
                        if (width_i == 2'b11 || (split_in && !MisalignedEn)) begin
                            state_q <= StErr;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q      <= StReq1;
                            data_req_q   <= 1'b1;
                            data_addr_q  <= {addr_i[31:2], 2'b00};
                            data_we_q    <= we_i;
                            data_be_q    <= be1;
                            data_wdata_q <= wdata1;
                        end
                    end
                end
                StReq1: begin
                    if (data_if.gnt) begin
                        data_req_q <= 1'b0;
                        state_q    <= StWait1;
                    end
                end
                StWait1: begin
                    if (data_if.rvalid) begin
                        if (split_q) begin
                            rd1_q        <= data_if.rdata;
                            state_q      <= StReq2;
                            data_req_q   <= 1'b1;
                            data_addr_q  <= data_addr_q + 32'd4;
                            data_be_q    <= be2;
                            data_wdata_q <= wdata2;
                        end else begin
                            state_q <= StDone;
                            valid_q <= 1'b1;
                            if (!data_we_q) rdata_q <= load_ext;
                        end
                    end
                end
                StReq2: begin
                    if (data_if.gnt) begin
                        data_req_q <= 1'b0;
                        state_q    <= StWait2;
                    end
                end
                StWait2: begin
                    if (data_if.rvalid) begin
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        if (!data_we_q) rdata_q <= load_ext;
                    end
                end
                StDone: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
                StErr: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign valid_o       = valid_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign data_if.req   = data_req_q;
    assign data_if.addr  = data_addr_q;
    assign data_if.we    = data_we_q;
    assign data_if.be    = data_be_q;
    assign data_if.wdata = data_wdata_q;

endmodule

// File: tb/tb_panda_load_store_unit.sv
// Directed bench for panda_load_store_unit: a word memory model with optional random
// gnt/rvalid delays, plus a second instance with misaligned accesses disabled.
module tb_panda_load_store_unit;

    logic        clk;
    logic        rst_ni;
    logic        req, req2;
    logic        we;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, valid, err;
    logic [31:0] rdata;
    logic        busy2, valid2, err2;
    logic [31:0] rdata2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [16];
    bit          mem_rand = 0;
    int          rv_extra = 0;
    int          txn_cnt  = 0;
    logic [31:0] txn_addr  [8];
    logic [3:0]  txn_be    [8];
    logic [31:0] txn_wdata [8];
    logic        txn_we    [8];
    logic        req2_seen = 1'b0;

    panda_load_store_unit_if mif ();
    panda_load_store_unit_if mif2 ();

    panda_load_store_unit #(.MisalignedEn(1'b1)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req),
        .we_i       (we),
        .width_i    (width),
        .unsigned_i (uns),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .valid_o    (valid),
        .err_o      (err),
        .rdata_o    (rdata),
        .data_if    (mif.master)
    );

    panda_load_store_unit #(.MisalignedEn(1'b0)) u_dut_noalign (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req2),
        .we_i       (we),
        .width_i    (width),
        .unsigned_i (uns),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy2),
        .valid_o    (valid2),
        .err_o      (err2),
        .rdata_o    (rdata2),
        .data_if    (mif2.master)
    );

    assign mif2.gnt    = 1'b0;
    assign mif2.rvalid = 1'b0;
    assign mif2.rdata  = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mif2.req === 1'b1) req2_seen <= 1'b1;

    // Memory model: grants and answers on negedges, logs every granted transaction.
    initial begin
        int          d;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        twe;
        logic [31:0] ta, twd;
        logic [3:0]  tbe;
        mif.gnt    = 1'b0;
        mif.rvalid = 1'b0;
        mif.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            mif.gnt    = 1'b0;
            mif.rvalid = 1'b0;
            if (mif.req === 1'b1 && rst_ni) begin
                d  = mem_rand ? $urandom_range(0, 3) : 0;
                a0 = mif.addr; b0 = mif.be; w0 = mif.wdata;
                repeat (d) @(negedge clk);
                if (d > 0) begin
                    n_checks++;
                    if (mif.req !== 1'b1 || mif.addr !== a0 || mif.be !== b0
                        || mif.wdata !== w0)
                        $display("FAIL stall_stable: req=%b addr=%h be=%b wdata=%h, required 1 %h %b %h",
                                 mif.req, mif.addr, mif.be, mif.wdata, a0, b0, w0);
                    else n_pass++;
                end
                ta = mif.addr; tbe = mif.be; twd = mif.wdata; twe = mif.we;
                if (txn_cnt < 8) begin
                    txn_addr[txn_cnt] = ta; txn_be[txn_cnt] = tbe;
                    txn_wdata[txn_cnt] = twd; txn_we[txn_cnt] = twe;
                end
                txn_cnt++;
                mif.gnt = 1'b1;
                @(negedge clk);
                mif.gnt = 1'b0;
                d = (mem_rand ? $urandom_range(0, 3) : 0) + rv_extra;
                repeat (d) @(negedge clk);
                if (twe) begin
                    for (int k = 0; k < 4; k++)
                        if (tbe[k]) mem[ta[5:2]][8*k +: 8] = twd[8*k +: 8];
                end else begin
                    mif.rdata = mem[ta[5:2]];
                end
                mif.rvalid = 1'b1;
            end
        end
    end

    // Issue one access and return at the negedge where valid_o is seen (or the bound expires).
    task automatic do_access(input logic w_e, input logic [1:0] w, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, output int cyc);
        @(negedge clk);
        txn_cnt = 0;
        req = 1'b1; we = w_e; width = w; uns = u; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (valid !== 1'b1 && cyc < 40);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, valid, err, mif.req, mif.we} !== 5'b0)
            $display("FAIL reset_ctrl: busy/valid/err/req/we=%b, required 00000",
                     {busy, valid, err, mif.req, mif.we});
        else n_pass++;
        n_checks++;
        if (mif.be !== 4'h0 || mif.addr !== 32'h0 || mif.wdata !== 32'h0)
            $display("FAIL reset_bus: be=%b addr=%h wdata=%h, required zeros",
                     mif.be, mif.addr, mif.wdata);
        else n_pass++;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", rdata);
        else n_pass++;
    endtask

    task automatic test_aligned_load();
        int cyc;
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h1234DEAD || err !== 1'b0)
            $display("FAIL lw_10: rdata=%h err=%b, required 1234dead 0", rdata, err);
        else n_pass++;
        n_checks++;
        if (cyc != 3) $display("FAIL lw_latency: got %0d cycles, required 3", cyc);
        else n_pass++;
        n_checks++;
        if (txn_cnt != 1 || txn_addr[0] !== 32'h10 || txn_be[0] !== 4'b1111)
            $display("FAIL lw_txn: cnt=%0d addr=%h be=%b, required 1 00000010 1111",
                     txn_cnt, txn_addr[0], txn_be[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) $display("FAIL valid_pulse: valid=%b one cycle later, required 0", valid);
        else n_pass++;
    endtask

    task automatic test_byte_half();
        int cyc;
        do_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'hFFFFFFDE || txn_be[0] !== 4'b0010)
            $display("FAIL lb_11: rdata=%h be=%b, required ffffffde 0010", rdata, txn_be[0]);
        else n_pass++;
        do_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h000000DE) $display("FAIL lbu_11: got %h, required 000000de", rdata);
        else n_pass++;
        do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h00001234 || txn_be[0] !== 4'b1100 || cyc != 3)
            $display("FAIL lh_12: rdata=%h be=%b cyc=%0d, required 00001234 1100 3",
                     rdata, txn_be[0], cyc);
        else n_pass++;
    endtask

    task automatic test_split_load();
        int cyc;
        do_access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h00007812) $display("FAIL lh_13: got %h, required 00007812", rdata);
        else n_pass++;
        n_checks++;
        if (txn_cnt != 2 || txn_addr[0] !== 32'h10 || txn_addr[1] !== 32'h14
            || txn_be[0] !== 4'b1000 || txn_be[1] !== 4'b0001)
            $display("FAIL lh_13_txn: cnt=%0d a0=%h a1=%h be0=%b be1=%b, required 2 10 14 1000 0001",
                     txn_cnt, txn_addr[0], txn_addr[1], txn_be[0], txn_be[1]);
        else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'hEF781234 || cyc != 5)
            $display("FAIL lw_12: rdata=%h cyc=%0d, required ef781234 5", rdata, cyc);
        else n_pass++;
    endtask

    task automatic test_random_delay();
        int cyc;
        mem_rand = 1;
        do_access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'hEF781234) $display("FAIL rnd_lw_12: got %h, required ef781234", rdata);
        else n_pass++;
        do_access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'hFFFFABCD) $display("FAIL rnd_lh_16: got %h, required ffffabcd", rdata);
        else n_pass++;
        do_access(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h000000CD) $display("FAIL rnd_lbu_16: got %h, required 000000cd", rdata);
        else n_pass++;
        do_access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h00007812) $display("FAIL rnd_lhu_13: got %h, required 00007812", rdata);
        else n_pass++;
        mem_rand = 0;
    endtask

    task automatic test_error();
        int          cyc;
        logic [31:0] prev;
        prev = rdata;
        do_access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, cyc);
        n_checks++;
        if (err !== 1'b1 || cyc != 1 || txn_cnt != 0 || rdata !== prev)
            $display("FAIL err_width: err=%b cyc=%0d txns=%0d rdata=%h, required 1 1 0 %h",
                     err, cyc, txn_cnt, rdata, prev);
        else n_pass++;
        @(negedge clk);
        req2 = 1'b1; we = 1'b0; width = 2'b10; uns = 1'b0; addr = 32'h11;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid2 !== 1'b1 || err2 !== 1'b1)
            $display("FAIL err_misaligned: valid=%b err=%b, required 1 1", valid2, err2);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req2_seen !== 1'b0 || busy2 !== 1'b0 || valid2 !== 1'b0)
            $display("FAIL err_no_req: req_seen=%b busy=%b valid=%b, required 0 0 0",
                     req2_seen, busy2, valid2);
        else n_pass++;
    endtask

    task automatic test_store();
        int          cyc;
        logic [31:0] prev;
        prev = rdata;
        do_access(1'b1, 2'b10, 1'b0, 32'h0E, 32'hAABBCCDD, cyc);
        n_checks++;
        if (txn_cnt != 2 || txn_addr[0] !== 32'h0C || txn_be[0] !== 4'b1100
            || txn_wdata[0] !== 32'hCCDD0000 || txn_we[0] !== 1'b1)
            $display("FAIL sw_txn1: cnt=%0d addr=%h be=%b wdata=%h we=%b, required 2 0c 1100 ccdd0000 1",
                     txn_cnt, txn_addr[0], txn_be[0], txn_wdata[0], txn_we[0]);
        else n_pass++;
        n_checks++;
        if (txn_addr[1] !== 32'h10 || txn_be[1] !== 4'b0011 || txn_wdata[1] !== 32'h0000AABB)
            $display("FAIL sw_txn2: addr=%h be=%b wdata=%h, required 10 0011 0000aabb",
                     txn_addr[1], txn_be[1], txn_wdata[1]);
        else n_pass++;
        n_checks++;
        if (rdata !== prev || cyc != 5)
            $display("FAIL sw_done: rdata=%h cyc=%0d, required %h 5", rdata, cyc, prev);
        else n_pass++;
        do_access(1'b1, 2'b00, 1'b0, 32'h0D, 32'h00000055, cyc);
        n_checks++;
        if (txn_be[0] !== 4'b0010 || txn_wdata[0] !== 32'h00005500)
            $display("FAIL sb_0d: be=%b wdata=%h, required 0010 00005500", txn_be[0], txn_wdata[0]);
        else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'h1234AABB) $display("FAIL lw_after_sw: got %h, required 1234aabb", rdata);
        else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'hCCDD5500) $display("FAIL lw_0c: got %h, required ccdd5500", rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen_valid;
        rv_extra = 4;
        @(negedge clk);
        txn_cnt = 0;
        req = 1'b1; we = 1'b0; width = 2'b10; uns = 1'b0; addr = 32'h10;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || mif.req !== 1'b0)
            $display("FAIL rst_mid: busy=%b req=%b, required 0 0", busy, mif.req);
        else n_pass++;
        @(negedge clk);
        rst_ni = 1'b1;
        seen_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid === 1'b1) seen_valid = 1;
        end
        n_checks++;
        if (seen_valid || busy !== 1'b0)
            $display("FAIL rst_discard: valid_seen=%b busy=%b, required 0 0", seen_valid, busy);
        else n_pass++;
        rv_extra = 0;
        do_access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, cyc);
        n_checks++;
        if (rdata !== 32'hABCDEF78 || cyc != 3)
            $display("FAIL lw_after_rst: rdata=%h cyc=%0d, required abcdef78 3", rdata, cyc);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h1234DEAD;
        mem[5] = 32'hABCDEF78;
        rst_ni = 1'b0;
        req = 1'b0; req2 = 1'b0; we = 1'b0; width = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_ni = 1'b1;
        @(negedge clk);
        test_aligned_load();
        test_byte_half();
        test_split_load();
        test_random_delay();
        test_error();
        test_store();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
